// File: rtl/rover_dispatcher.sv
// rover_dispatcher: collects ward calls, steers the rover to the next one in ring order and dwells there.
// Build option: define ROVER_PRIORITY_EN to always serve location 0 (ICU) first when it is pending.
module rover_dispatcher #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] call_req,
    input  logic [2:0] current_loc,
    output logic       move_switch,
    output logic [2:0] target_loc,
    output logic [7:0] pending,
    output logic       busy,
    output logic       arrived
);
    typedef enum logic [1:0] {IDLE, SELECT, MOVE, DWELL} state_t;
    state_t state, next_state;
    logic [2:0] steps;
    logic [7:0] dwell_cnt;
    logic [2:0] sel_tgt;
    logic [7:0] clear_mask;
    logic [7:0] others;
    // Next target: nearest pending call walking forward from the rover, optionally ICU first
    always_comb begin
        sel_tgt = current_loc;
        for (int i = 7; i >= 0; i--)
            if (pending[current_loc + 3'(i)]) sel_tgt = current_loc + 3'(i);
`ifdef ROVER_PRIORITY_EN
        if (pending[0]) sel_tgt = 3'd0;
`else
        sel_tgt = sel_tgt;
`endif
    end
    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end
    // Next-state logic
    always_comb begin
        others = pending & ~(8'd1 << target_loc);
        case (state)
            IDLE:    next_state = |pending ? SELECT : IDLE;
            SELECT:  next_state = ~|pending ? IDLE : (sel_tgt == current_loc ? DWELL : MOVE);
            MOVE:    next_state = steps == 3'd1 ? DWELL : MOVE;
            DWELL:   next_state = dwell_cnt == 8'd1 ? (|others ? SELECT : IDLE) : DWELL;
            default: next_state = IDLE;
        endcase
    end
    // Outputs decoded purely from registered state
    always_comb begin
        move_switch = state == MOVE;
        busy        = state != IDLE;
        arrived     = state == DWELL && dwell_cnt == 8'(DWELL_CYCLES);
    end
    // Target bit is absorbed on the edge entering dwell and throughout dwell
    always_comb begin
        clear_mask = (state == DWELL || next_state == DWELL)
                   ? 8'd1 << (state == SELECT ? sel_tgt : target_loc) : 8'd0;
    end
    // Call latch, target register, step and dwell counters
    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= 8'd0;
            target_loc <= 3'd0;
            steps      <= 3'd0;
            dwell_cnt  <= 8'd0;
        end else begin
            pending <= (pending | call_req) & ~clear_mask;
            if (state == SELECT) begin
                target_loc <= sel_tgt;
                steps      <= sel_tgt - current_loc;
            end else if (state == MOVE) begin
                steps <= steps - 3'd1;
            end
            if (next_state == DWELL && state != DWELL) dwell_cnt <= 8'(DWELL_CYCLES);
            else if (state == DWELL) dwell_cnt <= dwell_cnt - 8'd1;
        end
    end
endmodule

// File: tb/tb_rover_dispatcher.sv
// tb_rover_dispatcher: randomized and directed checks of the dispatcher against a service-order model.
module tb_rover_dispatcher;
    logic       clk = 0;
    logic       reset = 1;
    logic [7:0] call_req = 8'd0;
    logic [2:0] loc = 3'd0;
    logic       ld = 0;
    logic [2:0] ld_val = 3'd0;
    logic       move_switch;
    logic [2:0] target_loc;
    logic [7:0] pending;
    logic       busy;
    logic       arrived;

    int total = 0;
    int bad = 0;
    int n_arr, busy_cyc, timed_out;
    int a_tgt[8], a_loc[8], a_steps[8], a_cyc[8];
    int m_n;
    int m_tgt[8], m_steps[8];

    rover_dispatcher #(.DWELL_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .call_req(call_req), .current_loc(loc),
        .move_switch(move_switch), .target_loc(target_loc), .pending(pending),
        .busy(busy), .arrived(arrived)
    );

    always #5 clk = ~clk;

    // behavioural rover
    always @(posedge clk) begin
        if (ld) loc <= ld_val;
        else if (move_switch) loc <= loc + 3'd1;
    end

    function automatic int pick(input int p, input int l);
`ifdef ROVER_PRIORITY_EN
        if ((p & 1) != 0) return 0;
`endif
        for (int i = 0; i < 8; i++) if (((p >> ((l + i) % 8)) & 1) != 0) return (l + i) % 8;
        return l;
    endfunction

    function automatic void model(input int mask, input int l0);
        int p, l, t;
        p = mask; l = l0; m_n = 0;
        while (p != 0) begin
            t = pick(p, l);
            m_tgt[m_n] = t;
            m_steps[m_n] = (t - l + 8) % 8;
            m_n++;
            p = p & ~(1 << t);
            l = t;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk); reset = 1; call_req = 8'hFF;
        repeat (2) @(negedge clk);
        reset = 0; call_req = 8'h00;
    endtask

    task automatic set_loc(input logic [2:0] v);
        @(negedge clk); ld = 1; ld_val = v;
        @(negedge clk); ld = 0;
    endtask

    // drives a call pattern and records every arrival until the dispatcher is idle again
    task automatic run_calls(input logic [7:0] mask, input int hold);
        int st;
        st = 0; n_arr = 0; busy_cyc = 0; timed_out = 0;
        @(negedge clk); call_req = mask;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (j == hold - 1) call_req = 8'h00;
            if (move_switch) st++;
            if (busy) busy_cyc++;
            if (arrived) begin
                if (n_arr < 8) begin
                    a_tgt[n_arr] = int'(target_loc); a_loc[n_arr] = int'(loc);
                    a_steps[n_arr] = st; a_cyc[n_arr] = j;
                end
                n_arr++; st = 0;
            end
            if (j >= hold + 1 && !busy && pending == 8'd0) return;
        end
        timed_out = 1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (move_switch !== 1'b0) begin bad++; $display("FAIL reset_move got=%b exp=0", move_switch); end
        total++; if (target_loc !== 3'd0) begin bad++; $display("FAIL reset_target got=%0d exp=0", target_loc); end
        total++; if (pending !== 8'h00) begin bad++; $display("FAIL reset_pending got=%h exp=00", pending); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (arrived !== 1'b0) begin bad++; $display("FAIL reset_arrived got=%b exp=0", arrived); end
    endtask

    task automatic test_basic();
        set_loc(3'd0); run_calls(8'h08, 1);
        total++; if (timed_out != 0 || n_arr != 1) begin bad++; $display("FAIL basic_count got=%0d exp=1 timeout=%0d", n_arr, timed_out); end
        total++; if (a_tgt[0] != 3 || a_loc[0] != 3) begin bad++; $display("FAIL basic_target got=%0d/%0d exp=3/3", a_tgt[0], a_loc[0]); end
        total++; if (a_steps[0] != 3) begin bad++; $display("FAIL basic_steps got=%0d exp=3", a_steps[0]); end
        total++; if (a_cyc[0] != 5) begin bad++; $display("FAIL basic_arrive_time got=%0d exp=5", a_cyc[0]); end
        total++; if (busy_cyc != 8) begin bad++; $display("FAIL basic_busy got=%0d exp=8", busy_cyc); end
        total++; if (pending !== 8'h00) begin bad++; $display("FAIL basic_pending got=%h exp=00", pending); end
    endtask

    task automatic test_wrap();
        set_loc(3'd6); run_calls(8'h02, 1);
        total++; if (timed_out != 0 || n_arr != 1) begin bad++; $display("FAIL wrap_count got=%0d exp=1 timeout=%0d", n_arr, timed_out); end
        total++; if (a_tgt[0] != 1 || a_loc[0] != 1) begin bad++; $display("FAIL wrap_target got=%0d/%0d exp=1/1", a_tgt[0], a_loc[0]); end
        total++; if (a_steps[0] != 3) begin bad++; $display("FAIL wrap_steps got=%0d exp=3", a_steps[0]); end
        total++; if (busy_cyc != 8) begin bad++; $display("FAIL wrap_busy got=%0d exp=8", busy_cyc); end
    endtask

    task automatic test_ring_order();
        set_loc(3'd3); run_calls(8'h24, 1);
        total++; if (timed_out != 0 || n_arr != 2) begin bad++; $display("FAIL ring_count got=%0d exp=2 timeout=%0d", n_arr, timed_out); end
        total++; if (a_tgt[0] != 5 || a_steps[0] != 2 || a_loc[0] != 5) begin bad++; $display("FAIL ring_first got=%0d/%0d/%0d exp=5/2/5", a_tgt[0], a_steps[0], a_loc[0]); end
        total++; if (a_tgt[1] != 2 || a_steps[1] != 5 || a_loc[1] != 2) begin bad++; $display("FAIL ring_second got=%0d/%0d/%0d exp=2/5/2", a_tgt[1], a_steps[1], a_loc[1]); end
        total++; if (a_cyc[1] != 14) begin bad++; $display("FAIL ring_back_to_back got=%0d exp=14", a_cyc[1]); end
        total++; if (busy_cyc != 17) begin bad++; $display("FAIL ring_busy got=%0d exp=17", busy_cyc); end
    endtask

    task automatic test_local();
        set_loc(3'd4); run_calls(8'h10, 4);
        total++; if (timed_out != 0 || n_arr != 1) begin bad++; $display("FAIL local_count got=%0d exp=1 timeout=%0d", n_arr, timed_out); end
        total++; if (a_steps[0] != 0 || a_loc[0] != 4) begin bad++; $display("FAIL local_nomove got=%0d/%0d exp=0/4", a_steps[0], a_loc[0]); end
        total++; if (a_cyc[0] != 2) begin bad++; $display("FAIL local_arrive_time got=%0d exp=2", a_cyc[0]); end
        total++; if (busy_cyc != 5) begin bad++; $display("FAIL local_busy got=%0d exp=5", busy_cyc); end
        total++; if (pending !== 8'h00) begin bad++; $display("FAIL local_absorb got=%h exp=00", pending); end
    endtask

    task automatic test_priority();
        set_loc(3'd3); run_calls(8'h11, 1);
`ifdef ROVER_PRIORITY_EN
        total++; if (n_arr != 2 || a_tgt[0] != 0 || a_steps[0] != 5 || a_tgt[1] != 4 || a_steps[1] != 4) begin bad++; $display("FAIL priority_order got=%0d:%0d/%0d,%0d/%0d exp=2:0/5,4/4", n_arr, a_tgt[0], a_steps[0], a_tgt[1], a_steps[1]); end
`else
        total++; if (n_arr != 2 || a_tgt[0] != 4 || a_steps[0] != 1 || a_tgt[1] != 0 || a_steps[1] != 4) begin bad++; $display("FAIL priority_order got=%0d:%0d/%0d,%0d/%0d exp=2:4/1,0/4", n_arr, a_tgt[0], a_steps[0], a_tgt[1], a_steps[1]); end
`endif
    endtask

    task automatic test_reset_mid_move();
        set_loc(3'd0);
        @(negedge clk); call_req = 8'h20;
        @(negedge clk); call_req = 8'h00;
        repeat (2) @(negedge clk);
        total++; if (move_switch !== 1'b1) begin bad++; $display("FAIL midreset_moving got=%b exp=1", move_switch); end
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        total++; if (move_switch !== 1'b0 || busy !== 1'b0 || pending !== 8'h00) begin bad++; $display("FAIL midreset_clear got=%b/%b/%h exp=0/0/00", move_switch, busy, pending); end
        repeat (3) @(negedge clk);
        total++; if (loc !== 3'd2 || busy !== 1'b0) begin bad++; $display("FAIL midreset_stopped got=%0d/%b exp=2/0", loc, busy); end
    endtask

    task automatic test_random();
        int l, mask, exp_busy;
        for (int it = 0; it < 25; it++) begin
            l = $urandom_range(0, 7);
            mask = $urandom_range(1, 255);
            set_loc(3'(l));
            run_calls(8'(mask), 1);
            model(mask, l);
            exp_busy = 0;
            for (int i = 0; i < m_n; i++) exp_busy += 1 + m_steps[i] + 4;
            total++; if (timed_out != 0 || n_arr != m_n) begin bad++; $display("FAIL rand_count it=%0d got=%0d exp=%0d timeout=%0d", it, n_arr, m_n, timed_out); end
            else for (int i = 0; i < m_n; i++) begin
                total++; if (a_tgt[i] != m_tgt[i] || a_loc[i] != m_tgt[i] || a_steps[i] != m_steps[i]) begin bad++; $display("FAIL rand_service it=%0d n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", it, i, a_tgt[i], a_loc[i], a_steps[i], m_tgt[i], m_tgt[i], m_steps[i]); end
            end
            total++; if (busy_cyc != exp_busy) begin bad++; $display("FAIL rand_busy it=%0d got=%0d exp=%0d", it, busy_cyc, exp_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ring_order();
        test_local();
        test_priority();
        test_reset_mid_move();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rover_dispatcher.md
# rover_dispatcher

Ward-call dispatcher that drives the hospital rover. Collects call requests from eight ward stations and selects the next location to serve. Drives the rover's `move_switch` for exactly the number of steps needed to reach that location, then holds the rover for a fixed dwell time. It is the initiator for the rover FSM: it reads `current_loc` and writes `move_switch`.

## Interface
- `DWELL_CYCLES`, default 4: cycles the rover is held at a served location; legal range 1..255.
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high; clears all state on the next rising edge.
- `call_req` input 8: bit i high for ≥1 cycle requests service at location i; level-sampled every edge.
- `current_loc` input 3: rover location, straight from the rover.
- `move_switch` output 1: to the rover; decoded from the state register only (no input-to-output path).
- `target_loc` output 3: location being served; valid while `busy`.
- `pending` output 8: outstanding calls, bit i = call for location i not yet served.
- `busy` output 1: high whenever state ≠ IDLE.
- `arrived` output 1: one-cycle pulse on the first cycle of DWELL.

## Operation
- Rover contract: on every edge where `move_switch`=1, the rover advances `current_loc` by one, mod 8 (7→0). When `move_switch`=0 it holds.
- States: IDLE, SELECT, MOVE, DWELL.
- `pending` update per edge: `pending <= (pending | call_req) & ~clear_mask`.
  - `clear_mask` is the target bit on the edge entering DWELL and on every edge in DWELL.
  - Calls for the target location during dwell are therefore absorbed.
  - Calls for any other location are always kept.
- IDLE: if `pending`≠0, go to SELECT.
- SELECT, one cycle: target = first set bit of `pending` scanning `current_loc`, `current_loc`+1, … mod 8.
  - Register `target_loc`.
  - If target = `current_loc`, go to DWELL (no motion). Otherwise go to MOVE and load step counter d = (target − `current_loc`) mod 8, range 1..7.
  - If `pending`=0, go to IDLE.
- MOVE: `move_switch`=1. Decrement d each cycle; when d=1, go to DWELL on that edge. `move_switch` is therefore high for exactly d cycles.
- DWELL: `move_switch`=0.
  - Load dwell counter with DWELL_CYCLES on entry; `arrived`=1 in the first DWELL cycle only.
  - After DWELL_CYCLES cycles, go to SELECT if `pending` (excluding target) ≠0, else go to IDLE.
- `move_switch`=1 only in MOVE.
- Reset values: state=IDLE, `move_switch`=0, `target_loc`=0, `pending`=0, `busy`=0, `arrived`=0, both counters 0.
- Reset mid-MOVE: `move_switch` is low from the cycle after the reset edge. All pending calls are discarded. The rover position is not restored and stays wherever it stopped.
- `call_req` asserted during reset is ignored.

## Timing
- `call_req[i]` high at edge k: `pending[i]` set after k, SELECT after k+1, MOVE after k+2.
- `move_switch` is high for cycles k+2 .. k+1+d. `current_loc`=target and DWELL (with `arrived`) after edge k+2+d.
- Call for the current location from IDLE: `arrived` after edge k+2, with no `move_switch` pulse.
- Back-to-back service: DWELL → SELECT → MOVE, so there is one cycle of SELECT between the dwell end and the next movement.
- Total cycles per served call = 1 (SELECT) + d + DWELL_CYCLES.

## Configuration
- `ROVER_PRIORITY_EN` defined: location 0 (ICU) is priority. In SELECT, if `pending[0]`=1, target = 0 regardless of ring order. Otherwise the ring scan applies.
- Not defined: pure ring-order scan from `current_loc`. No location is favoured.

## Test plan
The bench includes a behavioural rover: a 3-bit counter that increments when `move_switch`=1. DWELL_CYCLES=4.
- **Basic move:** reset with loc=0, pulse `call_req`=8'h08 → `move_switch` high 3 cycles, loc 0→3, `arrived` 1 cycle, `busy` for 1+3+4 cycles after SELECT, `pending` back to 0.
- **Wrap-around:** loc=6, call 8'h02 → `move_switch` high 3 cycles, loc sequence 6,7,0,1, `target_loc`=1.
- **Ring order:** loc=3, calls 8'h24 (locations 2 and 5) together → serve 5 (2 steps), dwell, then 2 (5 steps via 6,7,0,1,2), then IDLE.
- **Local call:** loc=4, call 8'h10 → no `move_switch` pulse, `arrived` 2 cycles after the call edge. Re-asserting 8'h10 during DWELL leaves `pending`=0.
- **Reset mid-move:** assert `reset` on the 2nd MOVE cycle of a 5-step trip → `move_switch`=0 next cycle, `pending`=0, `busy`=0, rover stopped 2 steps along.
- **With `ROVER_PRIORITY_EN`:** loc=3, calls 8'h11 (locations 0 and 4) → target 0 first (5 steps), then 4. Without the macro, 4 first (1 step), then 0.
